// File: rtl/registered_tree.sv
// registered_tree: registered 32x32 signed multiplier with a full 64-bit product.
// Radix-4 Booth partial products feed a Wallace tree of row-wise 3:2 compressors.
// A single 64-bit carry-propagate add then resolves the two remaining rows.
// Operand registers and the output register give a fixed latency of two enabled edges.

// One Wallace level: every group of three rows is compressed into a sum row and a
// carry row (one full adder per bit column); leftover rows pass straight through.
module csa_layer #(
    parameter int N = 3,
    localparam int M = 2 * (N / 3) + (N % 3)
) (
    input  logic [N-1:0][63:0] rows_in,
    output logic [M-1:0][63:0] rows_out
);

    genvar gi;

    // Full-adder columns: sum stays in place, majority carry moves up one bit.
    generate
        for (gi = 0; gi < N / 3; gi++) begin : g_fa
            assign rows_out[2*gi]   = rows_in[3*gi] ^ rows_in[3*gi+1] ^ rows_in[3*gi+2];
            assign rows_out[2*gi+1] = ((rows_in[3*gi]   & rows_in[3*gi+1]) |
                                       (rows_in[3*gi]   & rows_in[3*gi+2]) |
                                       (rows_in[3*gi+1] & rows_in[3*gi+2])) << 1;
        end
    endgenerate

    // Rows that do not fill a full group of three wait for the next level.
    generate
        for (gi = 0; gi < N % 3; gi++) begin : g_pass
            assign rows_out[2*(N/3)+gi] = rows_in[3*(N/3)+gi];
        end
    endgenerate

endmodule

module registered_tree (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [63:0] out
);

    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [63:0] out_reg;
    logic [63:0] out_next;

    // Multiplicand sign-extended to the product width; all row arithmetic is mod 2^64,
    // so anything carried past bit 63 is simply dropped.
    logic [63:0] a_ext;
    // Multiplier with the implicit zero below bit 0 needed by the Booth recoder.
    logic [32:0] b_ext;
    // Sixteen Booth rows plus one row holding the +1 terms of negated rows.
    logic [16:0][63:0] rows_l0;
    logic [63:0]       corr_row;
    logic [15:0]       neg;

    logic [11:0][63:0] rows_l1;
    logic [7:0][63:0]  rows_l2;
    logic [5:0][63:0]  rows_l3;
    logic [3:0][63:0]  rows_l4;
    logic [2:0][63:0]  rows_l5;
    logic [1:0][63:0]  rows_l6;

    assign a_ext = {{32{a_reg[31]}}, a_reg};
    assign b_ext = {b_reg, 1'b0};

    genvar gi;

    // Radix-4 Booth recoding: each overlapping bit triple selects 0, +-A or +-2A.
    // The top triple includes the sign bit of b, so signed operands need no fix-up.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_booth
            logic [2:0]  trip;
            logic        sel_one;
            logic        sel_two;
            logic [63:0] mag;

            assign trip    = b_ext[2*gi+2 : 2*gi];
            assign sel_one = trip[0] ^ trip[1];
            assign sel_two = (trip == 3'b011) | (trip == 3'b100);
            assign neg[gi] = trip[2] & ~(trip[1] & trip[0]);
            assign mag     = sel_one ? a_ext : (sel_two ? (a_ext << 1) : 64'd0);
            // Negation is one's complement here; the missing +1 lives in corr_row.
            assign rows_l0[gi] = (neg[gi] ? ~mag : mag) << (2 * gi);

            assign corr_row[2*gi]   = neg[gi];
            assign corr_row[2*gi+1] = 1'b0;
        end
    endgenerate

    assign corr_row[63:32] = '0;
    assign rows_l0[16]     = corr_row;

    // Wallace reduction: 17 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2 rows.
    csa_layer #(.N(17)) u_l1 (.rows_in(rows_l0), .rows_out(rows_l1));
    csa_layer #(.N(12)) u_l2 (.rows_in(rows_l1), .rows_out(rows_l2));
    csa_layer #(.N(8))  u_l3 (.rows_in(rows_l2), .rows_out(rows_l3));
    csa_layer #(.N(6))  u_l4 (.rows_in(rows_l3), .rows_out(rows_l4));
    csa_layer #(.N(4))  u_l5 (.rows_in(rows_l4), .rows_out(rows_l5));
    csa_layer #(.N(3))  u_l6 (.rows_in(rows_l5), .rows_out(rows_l6));

    // Final carry-propagate add of the two surviving rows.
    assign out_next = rows_l6[0] + rows_l6[1];

    // Operand and product registers; reset wins over enable, enable low freezes all.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            out_reg <= '0;
        end else if (enable) begin
            a_reg   <= in1;
            b_reg   <= in2;
            out_reg <= out_next;
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_registered_tree.sv
// tb_registered_tree: directed and random checks of the registered 32x32 signed multiplier.
module tb_registered_tree;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [63:0] out;

    int compared;
    int mismatched;

    registered_tree dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .in1    (in1),
        .in2    (in2),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold one operand pair with enable high for n edges.
    task automatic drive_for(input logic [31:0] a, input logic [31:0] b, input int n);
        in1    = a;
        in2    = b;
        enable = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        in1    = 32'd0;
        in2    = 32'd0;
        repeat (2) tick();
        compared++;
        if (out !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_state: out=%h expected=%h", out, 64'd0);
        end else $display("reset_state: out=%h", out);
        reset = 1'b0;
        drive_for(-32'sd5, 32'sd5, 4);
        compared++;
        if (out !== 64'hFFFF_FFFF_FFFF_FFE7) begin
            mismatched++;
            $display("FAIL first_product -5*5: out=%h expected=%h", out, 64'hFFFF_FFFF_FFFF_FFE7);
        end else $display("first_product -5*5: out=%h", out);
    endtask

    task automatic test_sign_sweep();
        logic signed [31:0] ta [9] = '{4, -4, 2, 0, 1, 3, 5, 7, 0};
        logic signed [31:0] tb [9] = '{10, -10, -2, 3, 3, 7, 7, 7, 0};
        logic signed [63:0] te [9] = '{40, 40, -4, 0, 3, 21, 35, 49, 0};
        for (int i = 0; i < 9; i++) begin
            drive_for(ta[i], tb[i], 4);
            compared++;
            if (out !== te[i]) begin
                mismatched++;
                $display("FAIL sweep %0d*%0d: out=%h expected=%h", ta[i], tb[i], out, te[i]);
            end else $display("sweep %0d*%0d: out=%0d", ta[i], tb[i], $signed(out));
        end
    endtask

    task automatic test_extremes();
        logic [31:0] ta [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] tb [4] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [63:0] te [4] = '{64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000,
                                64'h3FFF_FFFF_0000_0001, 64'h0000_0000_8000_0000};
        for (int i = 0; i < 4; i++) begin
            drive_for(ta[i], tb[i], 4);
            compared++;
            if (out !== te[i]) begin
                mismatched++;
                $display("FAIL extreme %h*%h: out=%h expected=%h", ta[i], tb[i], out, te[i]);
            end else $display("extreme %h*%h: out=%h", ta[i], tb[i], out);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] ta [6] = '{3, -7, 100, -1, 65536, 12345};
        logic signed [31:0] tb [6] = '{4, 6, -100, -1, 65536, -2};
        logic signed [63:0] te [6] = '{12, -42, -10000, 1, 64'sh1_0000_0000, -24690};
        enable = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                in1 = ta[k];
                in2 = tb[k];
            end else begin
                in1 = 32'd0;
                in2 = 32'd0;
            end
            tick();
            // Pair k-1 was captured one edge earlier, so its product lands on this edge.
            if (k >= 1) begin
                compared++;
                if (out !== te[k-1]) begin
                    mismatched++;
                    $display("FAIL back_to_back[%0d]: out=%h expected=%h", k - 1, out, te[k-1]);
                end else $display("back_to_back[%0d]: out=%0d", k - 1, $signed(out));
            end
        end
    endtask

    task automatic test_enable_hold();
        drive_for(32'sd3, 32'sd7, 4);
        enable = 1'b0;
        in1    = 32'sd9;
        in2    = 32'sd9;
        repeat (3) tick();
        compared++;
        if (out !== 64'd21) begin
            mismatched++;
            $display("FAIL enable_hold: out=%0d expected=21", $signed(out));
        end else $display("enable_hold: out=%0d", $signed(out));
        enable = 1'b1;
        tick();
        compared++;
        if (out !== 64'd21) begin
            mismatched++;
            $display("FAIL enable_resume_edge1: out=%0d expected=21", $signed(out));
        end else $display("enable_resume_edge1: out=%0d", $signed(out));
        tick();
        compared++;
        if (out !== 64'd81) begin
            mismatched++;
            $display("FAIL enable_resume_edge2: out=%0d expected=81", $signed(out));
        end else $display("enable_resume_edge2: out=%0d", $signed(out));
    endtask

    task automatic test_reset_midstream();
        drive_for(32'sd11, 32'sd13, 1);
        in1   = 32'sd6;
        in2   = 32'sd6;
        reset = 1'b1;
        tick();
        compared++;
        if (out !== 64'd0) begin
            mismatched++;
            $display("FAIL midreset_edge: out=%0d expected=0", $signed(out));
        end else $display("midreset_edge: out=%0d", $signed(out));
        reset = 1'b0;
        in1   = 32'sd2;
        in2   = 32'sd3;
        tick();
        compared++;
        if (out !== 64'd0) begin
            mismatched++;
            $display("FAIL midreset_flush: out=%0d expected=0", $signed(out));
        end else $display("midreset_flush: out=%0d", $signed(out));
        tick();
        compared++;
        if (out !== 64'd6) begin
            mismatched++;
            $display("FAIL midreset_recover: out=%0d expected=6", $signed(out));
        end else $display("midreset_recover: out=%0d", $signed(out));
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp_prev;
        int          errs_before;
        exp_prev    = 64'd0;
        errs_before = mismatched;
        enable      = 1'b1;
        for (int k = 0; k <= 10000; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            in1 = ra;
            in2 = rb;
            tick();
            if (k >= 1) begin
                compared++;
                if (out !== exp_prev) begin
                    mismatched++;
                    $display("FAIL random[%0d]: out=%h expected=%h", k - 1, out, exp_prev);
                end
            end
            exp_prev = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
            if (k % 1000 == 999)
                $display("random block ending %0d: errors so far %0d", k, mismatched - errs_before);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        in1        = 32'd0;
        in2        = 32'd0;
        test_reset();
        test_sign_sweep();
        test_extremes();
        test_back_to_back();
        test_enable_hold();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a stalled simulation.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, compared=%0d", compared);
        $fatal(1, "timeout");
    end

endmodule
